// File: rtl/xout_pkg.sv
// Shared definitions for the xout_buffer slice: legal upstream words,
// checker state encoding and the legality test.
package xout_pkg;

  localparam logic [3:0] LEGAL_W0 = 4'b0000;
  localparam logic [3:0] LEGAL_W1 = 4'b1010;

  typedef enum logic {
    MON   = 1'b0,
    ALARM = 1'b1
  } chk_state_e;

  function automatic logic is_legal(input logic [3:0] word);
    return (word == LEGAL_W0) || (word == LEGAL_W1);
  endfunction

endpackage

// File: rtl/xout_fifo.sv
// First-word-fall-through FIFO with registered head word, registered valid,
// and a saturating counter of words lost to a full queue.
module xout_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic [3:0]       din,
  output logic [3:0]       dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       mem_q [DEPTH];
  logic [3:0]       mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [3:0]       dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic full, empty, rd_en, wr_en, drop;

  // Occupancy flags from pointer comparison; extra MSB distinguishes full from empty.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  end

  // Next-state for storage, pointers, head register and drop counter.
  // The head word is computed from the post-update memory and read pointer so
  // dout stays a flop yet still shows a word written into an emptying queue.
  always_comb begin
    rd_en      = !empty && dout_rdy;
    wr_en      = in_en && (!full || rd_en);
    drop       = in_en && full && !rd_en;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
    dout_d     = mem_d[rd_ptr_d[AW-1:0]];
    dout_vld_d = (wr_ptr_d != rd_ptr_d);
  end

  // State registers; reset clears queued data at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: rtl/xout_buffer.sv
// Output buffer for the AND-reduce datapath: FIFO plus optional legality
// checker. Define XOUT_BUF_CHECK_EN to build the checker FSM and alarm counter;
// otherwise alarm and alarm_cnt read as zero and clr_alarm is ignored.
module xout_buffer
  import xout_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic [3:0]       din,
  output logic [3:0]       dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  input  logic             clr_alarm,
  output logic             alarm,
  output logic [CNT_W-1:0] alarm_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  xout_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_en    (in_en),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .drop_cnt (drop_cnt)
  );

`ifdef XOUT_BUF_CHECK_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
  logic             illegal;

  // Checker next state; an illegal word takes priority over clr_alarm.
  always_comb begin
    state_d     = state_q;
    alarm_cnt_d = alarm_cnt_q;
    illegal     = in_en && !is_legal(din);
    case (state_q)
      MON: begin
        if (illegal) begin
          state_d     = ALARM;
          alarm_cnt_d = clr_alarm ? CNT_ONE :
                        ((alarm_cnt_q == '1) ? alarm_cnt_q : alarm_cnt_q + CNT_ONE);
        end
      end
      ALARM: begin
        if (illegal) begin
          alarm_cnt_d = clr_alarm ? CNT_ONE :
                        ((alarm_cnt_q == '1) ? alarm_cnt_q : alarm_cnt_q + CNT_ONE);
        end else if (clr_alarm) begin
          state_d     = MON;
          alarm_cnt_d = '0;
        end
      end
      default: begin
        state_d     = MON;
        alarm_cnt_d = '0;
      end
    endcase
  end

  // Checker state and alarm counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MON;
      alarm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign alarm     = (state_q == ALARM);
  assign alarm_cnt = alarm_cnt_q;
`else
  logic unused_clr_alarm;
  assign unused_clr_alarm = clr_alarm;
  assign alarm            = 1'b0;
  assign alarm_cnt        = '0;
`endif

endmodule
